// File: rtl/mips_dbg_pkg.sv
// Shared types and constants for the MIPS trace monitor.
package mips_dbg_pkg;

    // Monitor run state
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } mon_state_e;

    // Capture mode select
    localparam logic MODE_ALL    = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    // Default widths of the 16-bit core
    localparam int unsigned TRACE_PC_W    = 13;
    localparam int unsigned TRACE_INSTR_W = 16;

    // One trace buffer entry, packed as {pc, instr}
    typedef struct packed {
        logic [TRACE_PC_W-1:0]    pc;
        logic [TRACE_INSTR_W-1:0] instr;
    } trace_entry_t;

endpackage

// File: rtl/trace_ring_buffer.sv
// Circular trace store: overwrites the oldest entry when full, pops over valid/ready.
module trace_ring_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 29
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    input  logic                       rd_ready_i,
    output logic                       rd_valid_o,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0]     entries_o,
    output logic                       overflow_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             full, pop;

    // Occupancy decode; data is forced to zero whenever nothing is offered
    always_comb begin
        full       = (count_q == FullCount);
        rd_valid_o = rd_en_i && (count_q != '0);
        pop        = rd_valid_o && rd_ready_i && !wr_en_i;
        rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
        entries_o  = count_q;
        overflow_o = ovf_q;
    end

    // Storage array; contents are never observed until written
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // Pointer, occupancy and sticky overflow bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else if (wr_en_i) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            if (full) begin
                // Oldest entry is overwritten, so the read side skips past it
                rd_ptr_q <= rd_ptr_q + 1'b1;
                ovf_q    <= 1'b1;
            end else begin
                count_q <= count_q + 1'b1;
            end
        end else if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q  <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/mips_trace_monitor.sv
// Execution-trace monitor: captures (PC, instr), detects halt/timeout, then drains oldest-first.
module mips_trace_monitor
    import mips_dbg_pkg::*;
#(
    parameter int unsigned PC_W        = 13,
    parameter int unsigned INSTR_W     = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned NUM_REGS    = 6,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned MAX_CYCLES  = 1024,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic [PC_W-1:0]              current_pc,
    input  logic [INSTR_W-1:0]           current_instr,
    input  logic [NUM_REGS*DATA_W-1:0]   rf_flat,
    output logic                         busy,
    output logic                         halted,
    output logic                         timeout,
    output logic                         overflow,
    output logic [CNT_W-1:0]             cycle_count,
    output logic [NUM_REGS*DATA_W-1:0]   rf_snapshot,
    output logic [$clog2(DEPTH):0]       entries,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [PC_W+INSTR_W-1:0]      rd_data,
    output logic                         rd_last
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = $clog2(HALT_CYCLES + 1);
    localparam logic [HW-1:0]    HaltLimit  = HW'(HALT_CYCLES);
    localparam logic [CNT_W-1:0] CycleLimit = CNT_W'(MAX_CYCLES);
    localparam logic [AW:0]      OneEntry   = (AW + 1)'(1);

    mon_state_e                 state_q;
    logic [CNT_W-1:0]           cycle_q;
    logic [HW-1:0]              halt_cnt_q;
    logic [PC_W-1:0]            prev_pc_q;
    logic                       first_q;
    logic                       halted_q, timeout_q;
    logic [NUM_REGS*DATA_W-1:0] snap_q;

    logic             arm, in_run, pc_changed, capture, halt_hit, timeout_hit, drain_end;
    logic [CNT_W-1:0] cycle_inc;
    logic [HW-1:0]    halt_inc;
    logic             buf_valid, buf_ovf;
    logic [AW:0]      buf_entries;

    // Per-cycle decisions for the run and drain phases
    always_comb begin
        arm         = start && ((state_q == StIdle) || (state_q == StDone));
        in_run      = (state_q == StRun);
        // First RUN cycle counts as a PC change regardless of the stale prev_pc
        pc_changed  = first_q || (current_pc != prev_pc_q);
        capture     = in_run && ((mode == MODE_ALL) || ((mode == MODE_CHANGE) && pc_changed));
        cycle_inc   = cycle_q + 1'b1;
        halt_inc    = halt_cnt_q + 1'b1;
        halt_hit    = !pc_changed && (halt_inc == HaltLimit);
        timeout_hit = (cycle_inc == CycleLimit);
        // Leave DRAIN on the edge that pops the final entry
        drain_end   = (buf_entries == '0) || ((buf_entries == OneEntry) && buf_valid && rd_ready);
    end

    // Monitor FSM with its registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            cycle_q    <= '0;
            halt_cnt_q <= '0;
            prev_pc_q  <= '0;
            first_q    <= 1'b0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            snap_q     <= '0;
        end else begin
            case (state_q)
                StIdle, StDone: begin
                    if (arm) begin
                        state_q    <= StRun;
                        cycle_q    <= '0;
                        halt_cnt_q <= '0;
                        prev_pc_q  <= '0;
                        first_q    <= 1'b1;
                        halted_q   <= 1'b0;
                        timeout_q  <= 1'b0;
                        snap_q     <= '0;
                    end
                end
                StRun: begin
                    cycle_q    <= cycle_inc;
                    first_q    <= 1'b0;
                    prev_pc_q  <= current_pc;
                    halt_cnt_q <= pc_changed ? '0 : halt_inc;
                    if (halt_hit || timeout_hit) begin
                        halted_q  <= halt_hit;
                        timeout_q <= timeout_hit;
                        snap_q    <= rf_flat;
                        state_q   <= StDrain;
                    end
                end
                StDrain: begin
                    if (drain_end) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    trace_ring_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (PC_W + INSTR_W)
    ) u_ring (
        .clk_i      (clk),
        .rst_ni     (rst),
        .clr_i      (arm),
        .wr_en_i    (capture),
        .wr_data_i  ({current_pc, current_instr}),
        .rd_en_i    (state_q == StDrain),
        .rd_ready_i (rd_ready),
        .rd_valid_o (buf_valid),
        .rd_data_o  (rd_data),
        .entries_o  (buf_entries),
        .overflow_o (buf_ovf)
    );

    // Output mapping
    always_comb begin
        busy        = (state_q == StRun) || (state_q == StDrain);
        halted      = halted_q;
        timeout     = timeout_q;
        overflow    = buf_ovf;
        cycle_count = cycle_q;
        rf_snapshot = snap_q;
        entries     = buf_entries;
        rd_valid    = buf_valid;
        rd_last     = buf_valid && (buf_entries == OneEntry);
    end

endmodule

// File: tb/tb_mips_trace_monitor.sv
// Scoreboard bench for mips_trace_monitor with a behavioural trace model.
module tb_mips_trace_monitor;

    localparam int PC_W        = 13;
    localparam int INSTR_W     = 16;
    localparam int DATA_W      = 16;
    localparam int NUM_REGS    = 6;
    localparam int DEPTH       = 16;
    localparam int HALT_CYCLES = 4;
    localparam int MAX_CYCLES  = 20;
    localparam int CNT_W       = 16;
    localparam int RFW         = NUM_REGS * DATA_W;
    localparam int EW          = PC_W + INSTR_W;
    localparam int AW          = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                mode = 1'b0;
    logic [PC_W-1:0]     current_pc = '0;
    logic [INSTR_W-1:0]  current_instr = '0;
    logic [RFW-1:0]      rf_flat = '0;
    logic                rd_ready = 1'b0;
    logic                busy, halted, timeout, overflow, rd_valid, rd_last;
    logic [CNT_W-1:0]    cycle_count;
    logic [RFW-1:0]      rf_snapshot;
    logic [AW:0]         entries;
    logic [EW-1:0]       rd_data;

    mips_trace_monitor #(
        .PC_W        (PC_W),
        .INSTR_W     (INSTR_W),
        .DATA_W      (DATA_W),
        .NUM_REGS    (NUM_REGS),
        .DEPTH       (DEPTH),
        .HALT_CYCLES (HALT_CYCLES),
        .MAX_CYCLES  (MAX_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .current_pc    (current_pc),
        .current_instr (current_instr),
        .rf_flat       (rf_flat),
        .busy          (busy),
        .halted        (halted),
        .timeout       (timeout),
        .overflow      (overflow),
        .cycle_count   (cycle_count),
        .rf_snapshot   (rf_snapshot),
        .entries       (entries),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_last       (rd_last)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every transfer and checks stall stability
    logic          held_v = 1'b0;
    logic [EW-1:0] held_d = '0;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst && held_v && rd_valid) chk("stall_hold", rd_data, held_d);
        if (rst && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_entry", rd_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", rd_data, e);
                chk("rd_last", rd_last, exp_q.size() == 0);
            end
        end
        held_v = rst && rd_valid && !rd_ready;
        held_d = rd_data;
    end

    // kind: 0 = PC 0,1,2,3 then stuck, 1 = PC increments forever, 2 = random walk
    // rdy_kind: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
    // abort_at >= 0 pulls reset that many cycles into the drain
    task automatic do_run(input int kind, input logic m, input int rdy_kind, input int abort_at);
        logic [EW-1:0]      trace[$];
        logic [PC_W-1:0]    pc, prev;
        logic [INSTR_W-1:0] ins;
        logic [RFW-1:0]     rf;
        logic [3:0]         pat;
        int                 cyc, run_len, n, keep, guard;
        bit                 halt, to, changed;
        pat = 4'b1001;
        prev = '0;
        rf = '0;
        @(posedge clk); #1;
        start = 1'b1;
        mode = m;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; run_len = 0; halt = 0; to = 0;
        while (!halt && !to) begin
            cyc++;
            case (kind)
                0:       pc = (cyc <= 4) ? PC_W'(cyc - 1) : PC_W'(3);
                1:       pc = PC_W'(cyc - 1);
                default: pc = (cyc > 1 && $urandom_range(0, 99) < 65) ? prev
                                                                      : PC_W'($urandom_range(0, 7));
            endcase
            ins = INSTR_W'($urandom);
            rf = {$urandom, $urandom, $urandom};
            if (kind == 0) rf[3*DATA_W +: DATA_W] = 16'h0007;
            current_pc = pc;
            current_instr = ins;
            rf_flat = rf;
            changed = (cyc == 1) || (pc != prev);
            if (!m || changed) trace.push_back({pc, ins});
            run_len = changed ? 1 : run_len + 1;
            halt = (run_len == HALT_CYCLES + 1);
            to = (cyc == MAX_CYCLES);
            prev = pc;
            @(posedge clk); #1;
        end
        n = trace.size();
        keep = (n > DEPTH) ? DEPTH : n;
        for (int i = n - keep; i < n; i++) exp_q.push_back(trace[i]);
        chk("busy_drain", busy, 1'b1);
        chk("halted", halted, halt);
        chk("timeout", timeout, to);
        chk("overflow", overflow, n > DEPTH);
        chk("cycle_count", cycle_count, cyc);
        chk("rf_snapshot", rf_snapshot, rf);
        if (kind == 0) chk("rf3", rf_snapshot[3*DATA_W +: DATA_W], 16'h0007);
        chk("entries", entries, keep);
        guard = 0;
        while (busy && guard < 200) begin
            case (rdy_kind)
                0:       rd_ready = 1'b1;
                1:       rd_ready = pat[guard % 4];
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
            if (abort_at >= 0 && guard == abort_at) begin
                #2;
                rst = 1'b0;
                #1;
                chk("rst_busy", busy, 1'b0);
                chk("rst_rd_valid", rd_valid, 1'b0);
                chk("rst_entries", entries, 0);
                chk("rst_halted", halted, 1'b0);
                chk("rst_cycle_count", cycle_count, 0);
                chk("rst_overflow", overflow, 1'b0);
                chk("rst_snapshot", rf_snapshot, 0);
                exp_q.delete();
                rd_ready = 1'b0;
                #3;
                rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            guard++;
        end
        rd_ready = 1'b0;
        chk("drain_bounded", busy, 1'b0);
        if (rdy_kind == 0) chk("drain_cycles", guard, keep);
        chk("leftover_expected", exp_q.size(), 0);
        chk("done_rd_valid", rd_valid, 1'b0);
        chk("done_halted_hold", halted, halt);
        chk("done_count_hold", cycle_count, cyc);
    endtask

    initial begin
        #12 rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);
        chk("idle_rd_valid", rd_valid, 1'b0);
        chk("idle_halted", halted, 1'b0);
        chk("idle_timeout", timeout, 1'b0);
        chk("idle_overflow", overflow, 1'b0);
        chk("idle_cycle_count", cycle_count, 0);
        chk("idle_entries", entries, 0);
        chk("idle_snapshot", rf_snapshot, 0);
        chk("idle_rd_last", rd_last, 1'b0);
        do_run(0, 1'b0, 0, -1);
        do_run(0, 1'b1, 1, -1);
        do_run(1, 1'b0, 0, -1);
        do_run(1, 1'b0, 1, -1);
        for (int r = 0; r < 10; r++) do_run(2, 1'($urandom_range(0, 1)), 2, -1);
        do_run(0, 1'b0, 1, 3);
        do_run(2, 1'b0, 0, -1);
        do_run(0, 1'b1, 0, -1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit");
    end

endmodule
